// File: rtl/tx_launch_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tx_launch_scheduler : releases TX frames to the sender once their header
// timestamp is reached. Revision 1.0
// ----------------------------------------------------------------------------
module tx_launch_scheduler #(
   parameter int HDR_WORDS = 7
) (
   input  logic        gmii_tx_clk,
   input  logic        sys_rst,
   input  logic [63:0] global_counter,
   input  logic        sched_en,
   input  logic        clr,
   input  logic [13:0] host_wr_ptr,
   input  logic [13:0] sender_rd_ptr,
   output logic [13:0] gated_wr_ptr,
   output logic [13:0] sched_addr,
   input  logic [15:0] sched_q,
   output logic        busy,
   output logic [31:0] released_frames,
   output logic [31:0] late_frames
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HDR     = 3'd1,
      S_CHECK   = 3'd2,
      S_WAIT    = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   state_t      r_state;
   logic [13:0] r_ptr;
   logic [13:0] r_addr;
   logic        r_busy;
   logic [31:0] r_rel;
   logic [31:0] r_late;
   logic [2:0]  r_hcnt;
   logic [13:0] r_len;
   logic [63:0] r_ts;
   logic        r_first_wait;
   logic        r_hold;

   logic [14:0] w_half;
   logic [13:0] w_fp;
   logic [13:0] w_end;
   logic        w_go;
   logic        w_release;
   logic        w_unused_q;

   assign w_half     = ({1'b0, r_len} + 15'd1) >> 1;
   assign w_fp       = 14'(HDR_WORDS) + w_half[13:0];
   assign w_end      = r_ptr + w_fp;
   // Only one frame in flight: the sender must have retired everything released.
   assign w_go       = !r_hold && (r_ptr < host_wr_ptr) && (sender_rd_ptr == r_ptr);
   assign w_release  = !sched_en || (r_ts == 64'd0) || (global_counter >= r_ts);
   assign w_unused_q = &sched_q[15:14];

   always_ff @(posedge gmii_tx_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state      <= S_IDLE;
         r_ptr        <= '0;
         r_addr       <= '0;
         r_busy       <= 1'b0;
         r_rel        <= '0;
         r_late       <= '0;
         r_hcnt       <= '0;
         r_len        <= '0;
         r_ts         <= '0;
         r_first_wait <= 1'b0;
         r_hold       <= 1'b0;
      end else if (clr) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_busy  <= 1'b0;
         r_hold  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (host_wr_ptr < r_ptr) begin
                  r_hold <= 1'b1;
               end else if (w_go) begin
                  r_state <= S_HDR;
                  r_addr  <= r_ptr;
                  r_hcnt  <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_HDR: begin
               // Word n arrives one cycle after its address, so capture lags by one.
               if (r_hcnt < 3'd4)
                  r_addr <= r_addr + 14'd1;
               case (r_hcnt)
                  3'd1:    r_len         <= sched_q[13:0];
                  3'd2:    r_ts[63:48]   <= sched_q;
                  3'd3:    r_ts[47:32]   <= sched_q;
                  3'd4:    r_ts[31:16]   <= sched_q;
                  3'd5: begin
                     r_ts[15:0] <= sched_q;
                     r_state    <= S_CHECK;
                  end
                  default: ;
               endcase
               r_hcnt <= r_hcnt + 3'd1;
            end
            S_CHECK: begin
               if (!(w_end > host_wr_ptr)) begin
                  r_state      <= S_WAIT;
                  r_first_wait <= 1'b1;
               end
            end
            S_WAIT: begin
               r_first_wait <= 1'b0;
               if (r_first_wait && sched_en && (r_ts != 64'd0) && (global_counter > r_ts))
                  r_late <= r_late + 32'd1;
               if (w_release)
                  r_state <= S_RELEASE;
            end
            S_RELEASE: begin
               r_ptr   <= w_end;
               r_rel   <= r_rel + 32'd1;
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign gated_wr_ptr    = r_ptr;
   assign sched_addr      = r_addr;
   assign busy            = r_busy;
   assign released_frames = r_rel;
   assign late_frames     = r_late;

endmodule
`default_nettype wire

// File: tb/tb_tx_launch_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tx_launch_scheduler : randomized bench for tx_launch_scheduler with a
// per-frame timing model. Revision 1.0
// ----------------------------------------------------------------------------
module tb_tx_launch_scheduler;

   localparam int HDR   = 7;
   localparam int NEVER = 32'h7fff_ffff;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] gc_base = '0;
   logic [63:0] cyc = '0;
   logic [63:0] global_counter;
   logic        sched_en;
   logic        clr;
   logic [13:0] host_wr_ptr;
   logic [13:0] sender_rd_ptr;
   logic [13:0] gated_wr_ptr;
   logic [13:0] sched_addr;
   logic [15:0] sched_q = '0;
   logic        busy;
   logic [31:0] released_frames;
   logic [31:0] late_frames;

   logic [15:0] mem [0:16383];

   int          errors = 0;
   int          checks = 0;
   logic [13:0] exp_ptr;
   int          exp_rel;
   int          exp_late;

   assign global_counter = gc_base + cyc;

   tx_launch_scheduler #(.HDR_WORDS(HDR)) dut (
      .gmii_tx_clk     (clk),
      .sys_rst         (rst),
      .global_counter  (global_counter),
      .sched_en        (sched_en),
      .clr             (clr),
      .host_wr_ptr     (host_wr_ptr),
      .sender_rd_ptr   (sender_rd_ptr),
      .gated_wr_ptr    (gated_wr_ptr),
      .sched_addr      (sched_addr),
      .sched_q         (sched_q),
      .busy            (busy),
      .released_frames (released_frames),
      .late_frames     (late_frames)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 64'd1;
   always @(posedge clk) sched_q <= mem[sched_addr];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int fp_of(input int len);
      return HDR + (len + 1) / 2;
   endfunction

   task automatic load_frame(input logic [13:0] start, input int len, input logic [63:0] ts);
      mem[start]         = {2'b00, 14'(len)};
      mem[start + 14'd1] = ts[63:48];
      mem[start + 14'd2] = ts[47:32];
      mem[start + 14'd3] = ts[31:16];
      mem[start + 14'd4] = ts[15:0];
      mem[start + 14'd5] = 16'($urandom);
      mem[start + 14'd6] = 16'($urandom);
      for (int i = 0; i < (len + 1) / 2; i++)
         mem[start + 14'(HDR + i)] = 16'($urandom);
   endtask

   // Edge index (counted from the edge that leaves IDLE) at which gated_wr_ptr
   // updates: parse needs 7 edges, commit check, then one WAIT edge per cycle
   // until a release condition holds, then one RELEASE edge.
   function automatic int exp_update(input int full_at, input logic en0, input int en_drop,
                                     input logic [63:0] ts, input logic [63:0] g0,
                                     output logic late);
      int wf;
      wf   = ((full_at > 7) ? full_at : 7) + 1;
      late = en0 && (wf < en_drop) && (ts != 64'd0) && (g0 + 64'(wf) > ts);
      for (int k = wf; k < wf + 100000; k++)
         if (!(en0 && (k < en_drop)) || (ts == 64'd0) || (g0 + 64'(k) >= ts))
            return k + 1;
      return -1;
   endfunction

   task automatic run_frame(input int len, input logic [63:0] ts, input logic [63:0] g0,
                            input logic en0, input int full_at, input int en_drop,
                            input int extra);
      logic [13:0] start;
      logic [13:0] full_host;
      int          fp;
      int          exp_k;
      int          got;
      int          k;
      logic        exp_l;
      start     = exp_ptr;
      fp        = fp_of(len);
      full_host = start + 14'(fp + extra);
      exp_k     = exp_update(full_at, en0, en_drop, ts, g0, exp_l);
      @(negedge clk);
      load_frame(start, len, ts);
      host_wr_ptr   = (full_at == 0) ? full_host : start + 14'd10;
      sender_rd_ptr = start;
      sched_en      = en0;
      gc_base       = g0 - cyc;
      k   = -1;
      got = -1;
      while (k < 1000 && got < 0) begin
         @(posedge clk);
         k++;
         #1;
         if (gated_wr_ptr != start) begin
            got = k;
         end else begin
            if (k + 1 == full_at) host_wr_ptr = full_host;
            if (k + 1 == en_drop) sched_en = 1'b0;
         end
      end
      exp_ptr = start + 14'(fp);
      exp_rel++;
      if (exp_l) exp_late++;
      chk("latency", 64'(got), 64'(exp_k));
      chk("gated_ptr", 64'(gated_wr_ptr), 64'(exp_ptr));
      chk("released", 64'(released_frames), 64'(exp_rel));
      chk("late", 64'(late_frames), 64'(exp_late));
      chk("addr_hold", 64'(sched_addr), 64'(start + 14'd4));
      chk("busy_idle", 64'(busy), 64'd0);
   endtask

   task automatic do_clr();
      @(negedge clk);
      clr           = 1'b1;
      host_wr_ptr   = '0;
      sender_rd_ptr = '0;
      @(posedge clk);
      #1;
      chk("clr_ptr", 64'(gated_wr_ptr), 64'd0);
      chk("clr_busy", 64'(busy), 64'd0);
      chk("clr_rel", 64'(released_frames), 64'(exp_rel));
      chk("clr_late", 64'(late_frames), 64'(exp_late));
      @(negedge clk);
      clr     = 1'b0;
      exp_ptr = '0;
   endtask

   initial begin
      logic [63:0] g;
      logic [63:0] ts;
      int          len;
      for (int i = 0; i < 16384; i++) mem[i] = '0;
      rst           = 1'b1;
      clr           = 1'b0;
      sched_en      = 1'b1;
      host_wr_ptr   = '0;
      sender_rd_ptr = '0;
      exp_ptr       = '0;
      exp_rel       = 0;
      exp_late      = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ptr", 64'(gated_wr_ptr), 64'd0);
      chk("rst_addr", 64'(sched_addr), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rel", 64'(released_frames), 64'd0);
      chk("rst_late", 64'(late_frames), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      run_frame(60, 64'd0, 64'h1234, 1'b1, 0, NEVER, 0);
      run_frame(60, 64'h1000, 64'h0F00, 1'b1, 0, NEVER, 0);
      run_frame(60, 64'h10, 64'h500, 1'b1, 0, NEVER, 0);

      do_clr();
      run_frame(61, 64'd0, 64'h40, 1'b1, 0, NEVER, 39);
      repeat (20) @(posedge clk);
      #1;
      chk("b2b_hold_ptr", 64'(gated_wr_ptr), 64'd38);
      chk("b2b_hold_busy", 64'(busy), 64'd0);
      run_frame(64, 64'd0, 64'h80, 1'b1, 0, NEVER, 0);
      chk("b2b_final", 64'(gated_wr_ptr), 64'd77);

      run_frame(60, 64'd0, 64'h2000, 1'b1, 15, NEVER, 0);
      run_frame(30, 64'h3000 + 64'd100000, 64'h3000, 1'b1, 0, 20, 0);
      run_frame(30, 64'h4000 + 64'd50, 64'h4000, 1'b0, 0, NEVER, 0);

      // Clear while a frame waits on a far-future timestamp.
      @(negedge clk);
      load_frame(exp_ptr, 20, 64'hFFFF_0000);
      host_wr_ptr   = exp_ptr + 14'(fp_of(20));
      sender_rd_ptr = exp_ptr;
      sched_en      = 1'b1;
      gc_base       = 64'h100 - cyc;
      repeat (12) @(posedge clk);
      #1;
      chk("wait_busy", 64'(busy), 64'd1);
      do_clr();

      for (int n = 0; n < 24; n++) begin
         len = int'($urandom_range(8, 200));
         g   = 64'($urandom) + 64'd1000;
         ts  = ($urandom_range(0, 2) == 0) ? 64'd0 : g + 64'($urandom_range(1, 80)) - 64'd40;
         run_frame(len, ts, g, ($urandom_range(0, 4) != 0),
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(8, 20)) : 0,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 15)) : NEVER, 0);
      end

      // host pointer behind scan pointer: nothing more is released until clr.
      @(negedge clk);
      sender_rd_ptr = exp_ptr;
      host_wr_ptr   = exp_ptr - 14'd3;
      repeat (3) @(posedge clk);
      @(negedge clk);
      load_frame(exp_ptr, 10, 64'd0);
      host_wr_ptr = exp_ptr + 14'd50;
      repeat (25) @(posedge clk);
      #1;
      chk("hold_ptr", 64'(gated_wr_ptr), 64'(exp_ptr));
      chk("hold_busy", 64'(busy), 64'd0);
      chk("hold_rel", 64'(released_frames), 64'(exp_rel));
      do_clr();

      // Asynchronous reset in the middle of header parsing.
      @(negedge clk);
      load_frame(14'd0, 40, 64'd0);
      host_wr_ptr   = 14'(fp_of(40));
      sender_rd_ptr = '0;
      sched_en      = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk("hdr_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      chk("arst_ptr", 64'(gated_wr_ptr), 64'd0);
      chk("arst_addr", 64'(sched_addr), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_rel", 64'(released_frames), 64'd0);
      chk("arst_late", 64'(late_frames), 64'd0);
      host_wr_ptr = '0;
      @(negedge clk);
      rst      = 1'b0;
      exp_ptr  = '0;
      exp_rel  = 0;
      exp_late = 0;
      run_frame(25, 64'h5000 - 64'd5, 64'h5000, 1'b1, 0, NEVER, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
